alu_seq_exec: RTL and testbench

//  Multi-cycle execute unit for the Y86 SEQ datapath: consumes valA/valB/ifun,

---
 rtl/alu_seq_exec_pkg.sv | 44 ++++
 rtl/alu_seq_exec_if.sv | 28 ++
 rtl/alu_seq_exec_slice.sv | 31 +++
 rtl/alu_seq_exec.sv | 129 ++++++++++++
 tb/tb_alu_seq_exec.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_exec_pkg.sv
// Shared ALU opcodes, condition selectors, CC bit positions and FSM states for the SEQ execute unit.
package y86_alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic lt;
        lt = cc[CC_SF] ^ cc[CC_OF];
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = lt | cc[CC_ZF];
            C_L:     cond_eval = lt;
            C_E:     cond_eval = cc[CC_ZF];
            C_NE:    cond_eval = ~cc[CC_ZF];
            C_GE:    cond_eval = ~lt;
            C_G:     cond_eval = ~lt & ~cc[CC_ZF];
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Decode-to-execute operand channel and execute-to-writeback result channel, plus CC/cnd status.
interface alu_seq_exec_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic             set_cc;
    logic [3:0]       cond_fn;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] val_e;
    logic             op_err;
    logic [2:0]       cc;
    logic             cnd;

    modport master (
        output in_valid, ifun, val_a, val_b, set_cc, cond_fn, out_ready,
        input  in_ready, out_valid, val_e, op_err, cc, cnd
    );

    modport slave (
        input  in_valid, ifun, val_a, val_b, set_cc, cond_fn, out_ready,
        output in_ready, out_valid, val_e, op_err, cc, cnd
    );
endinterface

// File: rtl/alu_seq_exec_slice.sv
// SLICE-bit combinational add/sub/and/xor with carry in/out; sub expects valA already inverted.
// Latency 0; no flow control.
module alu_slice
    import y86_alu_pkg::*;
#(
    parameter int SLICE = 16
) (
    input  logic [3:0]       i_ifun,
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_y,
    output logic             o_cout
);
    logic [SLICE:0] w_sum;

    always_comb begin
        w_sum  = {1'b0, i_b} + {1'b0, i_a} + {{SLICE{1'b0}}, i_cin};
        o_y    = '0;
        o_cout = 1'b0;
        case (i_ifun)
            ALU_ADD, ALU_SUB: begin
                o_y    = w_sum[SLICE-1:0];
                o_cout = w_sum[SLICE];
            end
            ALU_AND: o_y = i_b & i_a;
            ALU_XOR: o_y = i_b ^ i_a;
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq_exec.sv
// Slice-serial Y86 execute unit: valE and CC produced WIDTH/SLICE cycles after accept.
// Accepts only in IDLE; result and CC held in DONE until out_ready.
module alu_seq_exec
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_exec_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_s;
    logic [3:0]       r_ifun;
    logic             r_set_cc;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_val_e;
    logic             r_op_err;
    logic [2:0]       r_cc;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_y;
    logic             w_cout;
    logic [WIDTH-1:0] w_res;
    logic             w_last;
    logic             w_err;
    logic [WIDTH-1:0] w_val_e_fin;
    logic             w_of;
    logic [2:0]       w_cc_fin;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .i_ifun (r_ifun),
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_y    (w_y),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One shared slice; operands and partial result are addressed by r_idx each RUN cycle.
    always_comb begin
        w_a_slice = r_a[int'(r_idx)*SLICE +: SLICE];
        w_b_slice = r_b[int'(r_idx)*SLICE +: SLICE];
        w_res     = r_acc;
        w_res[int'(r_idx)*SLICE +: SLICE] = w_y;
        w_last      = (r_idx == IDXW'(NSLICE - 1));
        w_err       = (r_ifun > ALU_XOR);
        w_val_e_fin = w_err ? '0 : w_res;
        w_of        = 1'b0;
        case (r_ifun)
            ALU_ADD: w_of = (r_a_s == r_b[WIDTH-1]) && (w_val_e_fin[WIDTH-1] != r_a_s);
            ALU_SUB: w_of = (r_a_s != r_b[WIDTH-1]) && (w_val_e_fin[WIDTH-1] != r_b[WIDTH-1]);
            default: w_of = 1'b0;
        endcase
        w_cc_fin = '0;
        w_cc_fin[CC_ZF] = (w_val_e_fin == '0);
        w_cc_fin[CC_SF] = w_val_e_fin[WIDTH-1];
        w_cc_fin[CC_OF] = w_of;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_a_s    <= 1'b0;
            r_ifun   <= ALU_ADD;
            r_set_cc <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_val_e  <= '0;
            r_op_err <= 1'b0;
            r_cc     <= CC_RESET;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: if (bus.in_valid) begin
                    r_a      <= (bus.ifun == ALU_SUB) ? ~bus.val_a : bus.val_a;
                    r_a_s    <= bus.val_a[WIDTH-1];
                    r_b      <= bus.val_b;
                    r_ifun   <= bus.ifun;
                    r_set_cc <= bus.set_cc;
                    r_idx    <= '0;
                    r_carry  <= (bus.ifun == ALU_SUB);
                    r_acc    <= '0;
                end
                ST_RUN: begin
                    r_acc   <= w_res;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_val_e  <= w_val_e_fin;
                        r_op_err <= w_err;
                        if (r_set_cc && !w_err) r_cc <= w_cc_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.val_e     = r_val_e;
    assign bus.op_err    = r_op_err;
    assign bus.cc        = r_cc;
    assign bus.cnd       = cond_eval(bus.cond_fn, r_cc);
endmodule

// File: tb/tb_alu_seq_exec.sv
// Vector table plus scoreboard bench for alu_seq_exec, with reset-during-RUN sequence.
module tb_alu_seq_exec;
    import y86_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_exec_if #(.WIDTH(64)) bus ();

    alu_seq_exec #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic        set_cc;
        int          stall;
        logic [63:0] e;
        logic        err;
        logic [2:0]  cc;
    } vec_t;

    typedef struct {
        logic [63:0] e;
        logic        err;
        logic [2:0]  cc;
    } exp_t;

    vec_t vt[11];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] c);
        logic zf, sf, of;
        zf = c[2]; sf = c[1]; of = c[0];
        case (fn)
            4'd0:    ref_cnd = 1'b1;
            4'd1:    ref_cnd = (sf ^ of) | zf;
            4'd2:    ref_cnd = sf ^ of;
            4'd3:    ref_cnd = zf;
            4'd4:    ref_cnd = !zf;
            4'd5:    ref_cnd = !(sf ^ of);
            4'd6:    ref_cnd = !(sf ^ of) && !zf;
            default: ref_cnd = 1'b0;
        endcase
    endfunction

    task automatic run_op(input vec_t v, input int id);
        int   cyc;
        exp_t x;
        @(negedge clk);
        bus.ifun     = v.ifun;
        bus.val_a    = v.a;
        bus.val_b    = v.b;
        bus.set_cc   = v.set_cc;
        bus.in_valid = 1'b1;
        chk($sformatf("v%0d in_ready_idle", id), 64'(bus.in_ready), 64'd1);
        sb.push_back('{e: v.e, err: v.err, cc: v.cc});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!bus.out_valid && cyc < 20);
        chk($sformatf("v%0d latency", id), 64'(cyc), 64'd4);
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL v%0d scoreboard: got result, expected none", id);
            end else begin
                x = sb.pop_front();
                chk($sformatf("v%0d val_e", id), bus.val_e, x.e);
                chk($sformatf("v%0d op_err", id), 64'(bus.op_err), 64'(x.err));
                chk($sformatf("v%0d cc", id), 64'(bus.cc), 64'(x.cc));
            end
        end else begin
            void'(sb.pop_front());
        end
        for (int f = 0; f < 16; f++) begin
            bus.cond_fn = 4'(f);
            @(negedge clk);
            chk($sformatf("v%0d cnd fn%0d", id, f), 64'(bus.cnd), 64'(ref_cnd(4'(f), v.cc)));
        end
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.ifun     = ALU_XOR;
            bus.val_a    = 64'hDEAD_BEEF;
            chk($sformatf("v%0d stall%0d out_valid", id, s), 64'(bus.out_valid), 64'd1);
            chk($sformatf("v%0d stall%0d in_ready", id, s), 64'(bus.in_ready), 64'd0);
            chk($sformatf("v%0d stall%0d val_e", id, s), bus.val_e, v.e);
            chk($sformatf("v%0d stall%0d cc", id, s), 64'(bus.cc), 64'(v.cc));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk($sformatf("v%0d out_valid_drop", id), 64'(bus.out_valid), 64'd0);
        chk($sformatf("v%0d in_ready_back", id), 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.ifun      = '0;
        bus.val_a     = '0;
        bus.val_b     = '0;
        bus.set_cc    = 1'b0;
        bus.cond_fn   = C_E;
        bus.out_ready = 1'b0;

        vt[0]  = '{ALU_ADD, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0, 64'h8000_0000_0000_0000, 1'b0, 3'b011};
        vt[1]  = '{ALU_SUB, 64'h5, 64'h5, 1'b1, 0, 64'h0, 1'b0, 3'b100};
        vt[2]  = '{ALU_ADD, 64'h1, 64'h0000_0000_0000_FFFF, 1'b1, 0, 64'h1_0000, 1'b0, 3'b000};
        vt[3]  = '{ALU_AND, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_0000_FFFF_0000, 1'b1, 0,
                   64'h0F0F_0000_0F0F_0000, 1'b0, 3'b000};
        vt[4]  = '{ALU_XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 0, 64'hFFFF_FFFF_FFFF_EDCB, 1'b0, 3'b010};
        vt[5]  = '{ALU_SUB, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001};
        vt[6]  = '{ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 3, 64'h0, 1'b0, 3'b001};
        vt[7]  = '{4'd4, 64'h3, 64'h3, 1'b1, 0, 64'h0, 1'b1, 3'b001};
        vt[8]  = '{ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0, 64'h0, 1'b0, 3'b101};
        vt[9]  = '{ALU_SUB, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 0, 64'h8000_0000_0000_0000, 1'b0, 3'b011};
        vt[10] = '{ALU_SUB, 64'h1, 64'h1_0000, 1'b1, 0, 64'hFFFF, 1'b0, 3'b000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst val_e", bus.val_e, 64'd0);
        chk("rst op_err", 64'(bus.op_err), 64'd0);
        chk("rst cc", 64'(bus.cc), 64'(3'b100));
        chk("rst cnd E", 64'(bus.cnd), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_op(vt[i], i);

        // Abandon an add at idx=2 with a non-reset CC in place.
        @(negedge clk);
        bus.ifun = ALU_ADD; bus.val_a = 64'h1; bus.val_b = 64'h2; bus.set_cc = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid cc_held", 64'(bus.cc), 64'(3'b000));
        chk("mid in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst cc", 64'(bus.cc), 64'(3'b100));
        chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst val_e", bus.val_e, 64'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("postrst no_out", 64'(bus.out_valid), 64'd0);

        run_op('{ALU_ADD, 64'h2, 64'h3, 1'b1, 1, 64'h5, 1'b0, 3'b000}, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
